// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding
// the four digit inputs of the 7-segment display driver; saturates at MAX_DEC.
module score_bcd_conv #(
    parameter int BIN_W   = 14,
    parameter int MAX_DEC = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       num3,
    output logic [3:0]       num2,
    output logic [3:0]       num1,
    output logic [3:0]       num0
);
    // state | meaning
    // IDLE  | waiting for start; also the cycle in which done is high
    // SHIFT | one add-3 correction plus shift per edge, BIN_W edges in total
    // LOAD  | copy scratch nibbles to the digit outputs, pulse done
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0]  MAX_OP   = BIN_W'(MAX_DEC);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

    state_t             state, state_nx;
    logic               accept;
    logic [BIN_W-1:0]   operand;
    logic [15:0]        scratch;
    logic [15:0]        adj;
    logic [BIN_W+15:0]  shifted;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT:   if (cnt == CNT_LAST) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // All four nibbles are corrected in parallel before the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {adj, operand} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            num3    <= '0;
            num2    <= '0;
            num1    <= '0;
            num0    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                operand <= (bin > MAX_OP) ? MAX_OP : bin;
                ovf_int <= (bin > MAX_OP);
                scratch <= '0;
                cnt     <= CNT_INIT;
                busy    <= 1'b1;
            end else if (state == SHIFT) begin
                scratch <= shifted[BIN_W+15:BIN_W];
                operand <= shifted[BIN_W-1:0];
                cnt     <= cnt - CNT_LAST;
            end else if (state == LOAD) begin
                num3 <= scratch[15:12];
                num2 <= scratch[11:8];
                num1 <= scratch[7:4];
                num0 <= scratch[3:0];
                ovf  <= ovf_int;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: doc/score_bcd_conv.md
Name: score_bcd_conv

Overview:
- Sequential binary-to-BCD converter: takes the game's binary score and produces the four 4-bit decimal digits that feed the 7-segment display driver's num3..num0 digit inputs.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock. Start/busy/done handshake.
- Saturates out-of-range scores to 9999 and flags overflow.
- Sits between the score counter and the display driver in the top level.

Parameters:
- BIN_W, 14, width of binary input. Must be ≥ 14 and ≤ 16. Max representable input is 2^BIN_W-1.
- MAX_DEC, 9999, saturation value. Any input above this converts to 9,9,9,9.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only when busy=0.
- bin  in  BIN_W  binary score; captured on the accepting edge.
- busy  out  1  high from the accepting edge until done is asserted.
- done  out  1  one-cycle pulse when the digit outputs update.
- ovf  out  1  registered with the digits; 1 if the captured bin > MAX_DEC.
- num3  out  4  thousands digit (BCD), held between conversions.
- num2  out  4  hundreds digit.
- num1  out  4  tens digit.
- num0  out  4  units digit.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; busy=0, done=0, ovf=0, num3..num0=0. Internal operand, scratch and counter are cleared.
- States: IDLE, SHIFT, LOAD.
- IDLE: if start=1 at edge k:
  - capture bin into the operand register;
  - if bin > MAX_DEC, replace the operand with MAX_DEC and set an internal ovf flag, else clear it;
  - clear the 16-bit BCD scratch; set bit counter=BIN_W; busy=1; go to SHIFT.
- SHIFT, once per edge:
  - every scratch nibble ≥ 5 gets +3 (all nibbles corrected in parallel, combinationally, before the shift);
  - shift {scratch, operand} left by 1; decrement the counter;
  - when the counter reaches 1 on this edge (i.e. the last shift), go to LOAD. Exactly BIN_W shifts occur, at edges k+1..k+BIN_W.
- LOAD (edge k+BIN_W+1):
  - num3..num0 ← scratch nibbles [15:12]..[3:0]; ovf ← internal flag;
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle following edge k+BIN_W+1, i.e. 15 edges after acceptance for BIN_W=14.
- The done cycle is IDLE. A start present then is accepted, giving back-to-back conversions with no dead cycle.
- start while busy=1 is ignored (not queued). bin changes while busy have no effect.
- Outputs change only on the LOAD edge, so the display never shows partial results.
- Reset asserted mid-conversion: immediately return to IDLE, all outputs 0, and no done pulse is generated.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then start with bin=0 → after 15 edges done=1 for 1 cycle; digits 0,0,0,0; ovf=0; busy high for exactly 15 cycles.
- bin=1234, start 1 cycle → num3..num0 = 1,2,3,4; ovf=0; done pulse width 1; outputs hold 1,2,3,4 until the next done.
- bin=9999 → 9,9,9,9, ovf=0. Then bin=10000 → 9,9,9,9, ovf=1. Then bin=16383 → 9,9,9,9, ovf=1.
- Start bin=42, pulse start again with bin=7 at cycles 3 and 10 → only 0,0,4,2 is produced, with a single done. start held high with bin=7 during the done cycle → second conversion accepted, giving 0,0,0,7 exactly 15 edges later.
- Start bin=5678, deassert rst_n at cycle 8 for 2 cycles → outputs 0, busy=0, no done. After release, start bin=305 → 0,3,0,5.
- Random sweep of 1000 values in 0..16383 against the reference model min(v,9999) decimal split, checking ovf = (v>9999).
